// File: rtl/riscv_priv_pkg.sv
// riscv_priv_pkg: privilege encodings, controller FSM states and dcsr.prv legalisation
package riscv_priv_pkg;
   localparam logic [1:0] PRIV_USER    = 2'd0;
   localparam logic [1:0] PRIV_SUPER   = 2'd1;
   localparam logic [1:0] PRIV_MACHINE = 2'd3;
   typedef enum logic [1:0] {RUN, HALT, DEBUG, RESUME} state_t;
   // Reserved encoding 2 keeps the old value; S collapses to U without S-mode
   function automatic logic [1:0] warl_prv(input logic [1:0] wr, input logic [1:0] old, input logic sup);
      return (wr == 2'd2) ? old : (wr == PRIV_SUPER && !sup) ? PRIV_USER : wr;
   endfunction
endpackage

// File: rtl/riscv_priv_ctrl.sv
// riscv_priv_ctrl: privilege mode tracking across traps, xRET and debug halt/resume
module riscv_priv_ctrl
   import riscv_priv_pkg::*;
#(
   parameter logic SUPPORT_SUPER = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       trap_valid_i,
   input  logic       trap_deleg_i,
   input  logic       mret_i,
   input  logic       sret_i,
   input  logic       dbg_req_i,
   input  logic       dbg_resume_i,
   input  logic       dbg_prv_wr_i,
   input  logic [1:0] dbg_prv_i,
   output logic [1:0] priv_o,
   output logic [1:0] mpp_o,
   output logic       spp_o,
   output logic       dbg_mode_o,
   output logic       ack_o,
   output logic       illegal_o
);
   state_t     state;
   logic [1:0] dcsr_prv;
   logic [1:0] new_dcsr;
   logic [1:0] mret_priv;
   always_comb begin
      new_dcsr  = dbg_prv_wr_i ? warl_prv(dbg_prv_i, dcsr_prv, SUPPORT_SUPER) : dcsr_prv;
      mret_priv = (mpp_o == PRIV_SUPER && !SUPPORT_SUPER) ? PRIV_USER : mpp_o;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= RUN;
         priv_o     <= PRIV_MACHINE;
         mpp_o      <= PRIV_USER;
         spp_o      <= 1'b0;
         dcsr_prv   <= PRIV_MACHINE;
         dbg_mode_o <= 1'b0;
         ack_o      <= 1'b0;
         illegal_o  <= 1'b0;
      end else begin
         ack_o     <= 1'b0;
         illegal_o <= 1'b0;
         case (state)
            RUN: begin
               if (dbg_req_i) begin
                  state    <= HALT;
                  dcsr_prv <= priv_o;
                  ack_o    <= 1'b1;
               end else if (trap_valid_i) begin
                  ack_o <= 1'b1;
                  if (trap_deleg_i && SUPPORT_SUPER && priv_o != PRIV_MACHINE) begin
                     spp_o  <= priv_o[0];
                     priv_o <= PRIV_SUPER;
                  end else begin
                     mpp_o  <= priv_o;
                     priv_o <= PRIV_MACHINE;
                  end
               end else if (mret_i) begin
                  if (priv_o == PRIV_MACHINE) begin
                     priv_o <= mret_priv;
                     mpp_o  <= PRIV_USER;
                     ack_o  <= 1'b1;
                  end else
                     illegal_o <= 1'b1;
               end else if (sret_i) begin
                  if (priv_o == PRIV_USER || !SUPPORT_SUPER)
                     illegal_o <= 1'b1;
                  else begin
                     priv_o <= {1'b0, spp_o};
                     spp_o  <= 1'b0;
                     ack_o  <= 1'b1;
                  end
               end
            end
            HALT: begin
               state      <= DEBUG;
               dbg_mode_o <= 1'b1;
               priv_o     <= PRIV_MACHINE;
            end
            DEBUG: begin
               dcsr_prv <= new_dcsr;
               if (dbg_resume_i) begin
                  state      <= RESUME;
                  priv_o     <= new_dcsr;
                  dbg_mode_o <= 1'b0;
                  ack_o      <= 1'b1;
               end
            end
            RESUME: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_priv_ctrl.sv
// tb_riscv_priv_ctrl: directed checks of privilege transitions with and without S-mode
module tb_riscv_priv_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       trap_valid = 1'b0, trap_deleg = 1'b0, mret = 1'b0, sret = 1'b0;
   logic       dbg_req = 1'b0, dbg_resume = 1'b0, dbg_prv_wr = 1'b0;
   logic [1:0] dbg_prv = 2'd0;
   logic [1:0] d_priv, d_mpp, n_priv, n_mpp;
   logic       d_spp, d_dbg, d_ack, d_ill, n_spp, n_dbg, n_ack, n_ill;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   riscv_priv_ctrl #(.SUPPORT_SUPER(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .trap_valid_i(trap_valid), .trap_deleg_i(trap_deleg),
      .mret_i(mret), .sret_i(sret), .dbg_req_i(dbg_req), .dbg_resume_i(dbg_resume),
      .dbg_prv_wr_i(dbg_prv_wr), .dbg_prv_i(dbg_prv), .priv_o(d_priv), .mpp_o(d_mpp),
      .spp_o(d_spp), .dbg_mode_o(d_dbg), .ack_o(d_ack), .illegal_o(d_ill));

   riscv_priv_ctrl #(.SUPPORT_SUPER(1'b0)) dut_nos (
      .clk_i(clk), .rst_i(rst), .trap_valid_i(trap_valid), .trap_deleg_i(trap_deleg),
      .mret_i(mret), .sret_i(sret), .dbg_req_i(dbg_req), .dbg_resume_i(dbg_resume),
      .dbg_prv_wr_i(dbg_prv_wr), .dbg_prv_i(dbg_prv), .priv_o(n_priv), .mpp_o(n_mpp),
      .spp_o(n_spp), .dbg_mode_o(n_dbg), .ack_o(n_ack), .illegal_o(n_ill));

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      trap_valid = 1'b0; trap_deleg = 1'b0; mret = 1'b0; sret = 1'b0;
      dbg_req = 1'b0; dbg_resume = 1'b0; dbg_prv_wr = 1'b0; dbg_prv = 2'd0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_priv", d_priv, 2'd3);
      chk("rst_mpp", d_mpp, 2'd0);
      chk("rst_spp", d_spp, 0);
      chk("rst_dbg", d_dbg, 0);
      chk("rst_ack", d_ack, 0);
      chk("rst_ill", d_ill, 0);
      trap_valid = 1'b1; tick();
      chk("trapM_priv", d_priv, 2'd3);
      chk("trapM_mpp", d_mpp, 2'd3);
      chk("trapM_ack", d_ack, 1);
      mret = 1'b1; tick();
      chk("mret1_priv", d_priv, 2'd3);
      chk("mret1_mpp", d_mpp, 2'd0);
      chk("mret1_ack", d_ack, 1);
      mret = 1'b1; tick();
      chk("mret2_priv", d_priv, 2'd0);
      trap_valid = 1'b1; trap_deleg = 1'b1; tick();
      chk("trapS_priv", d_priv, 2'd1);
      chk("trapS_spp", d_spp, 0);
      chk("trapS_mpp", d_mpp, 2'd0);
      sret = 1'b1; tick();
      chk("sret_priv", d_priv, 2'd0);
      chk("sret_ack", d_ack, 1);
      sret = 1'b1; tick();
      chk("sretU_ill", d_ill, 1);
      chk("sretU_ack", d_ack, 0);
      chk("sretU_priv", d_priv, 2'd0);
      mret = 1'b1; tick();
      chk("mretU_ill", d_ill, 1);
      chk("mretU_priv", d_priv, 2'd0);
      tick();
      chk("ill_pulse", d_ill, 0);
      dbg_req = 1'b1; trap_valid = 1'b1; trap_deleg = 1'b1; tick();
      chk("halt_ack", d_ack, 1);
      chk("halt_priv", d_priv, 2'd0);
      chk("halt_dbg", d_dbg, 0);
      tick();
      chk("dbg_mode", d_dbg, 1);
      chk("dbg_priv", d_priv, 2'd3);
      chk("dbg_mpp", d_mpp, 2'd0);
      chk("dbg_ack", d_ack, 0);
      trap_valid = 1'b1; mret = 1'b1; tick();
      chk("dbg_trap_ack", d_ack, 0);
      chk("dbg_trap_priv", d_priv, 2'd3);
      sret = 1'b1; tick();
      chk("dbg_sret_ill", d_ill, 0);
      dbg_prv_wr = 1'b1; dbg_prv = 2'd2; tick();
      dbg_resume = 1'b1; tick();
      chk("res2_priv", d_priv, 2'd0);
      chk("res2_dbg", d_dbg, 0);
      chk("res2_ack", d_ack, 1);
      tick();
      dbg_resume = 1'b1; tick();
      chk("run_resume_ack", d_ack, 0);
      dbg_req = 1'b1; tick(); tick();
      chk("dbg2_mode", d_dbg, 1);
      dbg_prv_wr = 1'b1; dbg_prv = 2'd1; dbg_resume = 1'b1; tick();
      chk("res1_priv", d_priv, 2'd1);
      chk("res1_dbg", d_dbg, 0);
      tick();
      dbg_req = 1'b1; tick(); tick();
      chk("dbg3_mode", d_dbg, 1);
      rst = 1'b1;
      #1;
      chk("arst_dbg", d_dbg, 0);
      chk("arst_priv", d_priv, 2'd3);
      chk("arst_ack", d_ack, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      mret = 1'b1; tick();
      chk("arst_run_ack", d_ack, 1);
      chk("nos_mret_priv", n_priv, 2'd0);
      trap_valid = 1'b1; trap_deleg = 1'b1; tick();
      chk("nos_trap_priv", n_priv, 2'd3);
      chk("nos_trap_mpp", n_mpp, 2'd0);
      chk("sup_trap_priv", d_priv, 2'd1);
      sret = 1'b1; tick();
      chk("nos_sret_ill", n_ill, 1);
      chk("nos_sret_ack", n_ack, 0);
      chk("nos_sret_priv", n_priv, 2'd3);
      chk("sup_sret_priv", d_priv, 2'd0);
      dbg_req = 1'b1; tick(); tick();
      chk("nos_dbg_mode", n_dbg, 1);
      dbg_prv_wr = 1'b1; dbg_prv = 2'd1; tick();
      dbg_resume = 1'b1; tick();
      chk("nos_res_priv", n_priv, 2'd0);
      chk("sup_res_priv", d_priv, 2'd1);
      chk("nos_res_dbg", n_dbg, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/riscv_priv_ctrl.md
RISCV_PRIV_CTRL -- requirements
Module: riscv_priv_ctrl

Interface
REQ-001 SHALL have parameter SUPPORT_SUPER, default 1: 1 = S-mode implemented; 0 = S-mode absent, S targets map to U.
REQ-002 SHALL have port clk_i  input  1  core clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port trap_valid_i  input  1  exception/interrupt taken this cycle.
REQ-005 SHALL have port trap_deleg_i  input  1  trap is delegated to S (medeleg/mideleg hit).
REQ-006 SHALL have port mret_i  input  1  MRET retiring.
REQ-007 SHALL have port sret_i  input  1  SRET retiring.
REQ-008 SHALL have port dbg_req_i  input  1  halt request from debug module.
REQ-009 SHALL have port dbg_resume_i  input  1  resume request from debug module.
REQ-010 SHALL have port dbg_prv_wr_i  input  1  debugger write of dcsr.prv.
REQ-011 SHALL have port dbg_prv_i  input  2  dcsr.prv write data.
REQ-012 SHALL have port priv_o  output  2  current privilege to fetch/MMU (U=0, S=1, M=3).
REQ-013 SHALL have port mpp_o  output  2  mstatus.MPP.
REQ-014 SHALL have port spp_o  output  1  mstatus.SPP.
REQ-015 SHALL have port dbg_mode_o  output  1  core in debug mode.
REQ-016 SHALL have port ack_o  output  1  one-cycle pulse: event accepted.
REQ-017 SHALL have port illegal_o  output  1  one-cycle pulse: illegal return rejected.

Function
REQ-018 SHALL implement FSM RUN, HALT, DEBUG, RESUME; all outputs registered, update visible cycle after acceptance.
REQ-019 In RUN, simultaneous events SHALL be prioritised dbg_req_i > trap_valid_i > mret_i > sret_i; only highest acted on, others dropped.
REQ-020 Trap with trap_deleg_i=1, SUPPORT_SUPER=1 and priv_o!=M SHALL set spp<=priv_o[0], priv<=S; otherwise mpp<=priv_o, priv<=M.
REQ-021 MRET while priv_o==M SHALL set priv<=mpp (S->U when SUPPORT_SUPER=0), mpp<=U; MRET below M SHALL pulse illegal_o, no state change.
REQ-022 SRET while priv_o==U, or SUPPORT_SUPER=0, SHALL pulse illegal_o, no state change; otherwise priv<={1'b0,spp}, spp<=0.
REQ-023 Each accepted trap/mret/sret/dbg_req/dbg_resume SHALL pulse ack_o for exactly one cycle; rejected returns SHALL NOT assert ack_o.
REQ-024 dbg_req_i in RUN SHALL go HALT: save dcsr_prv<=priv, then DEBUG next cycle with dbg_mode_o=1, priv_o=M.
REQ-025 Effective privilege SHALL be raised only by trap entry or debug entry; no input other than these SHALL force priv_o to S or M.
REQ-026 In DEBUG, trap/mret/sret SHALL be ignored (no ack, no illegal); dbg_req_i ignored.
REQ-027 In DEBUG, dbg_prv_wr_i SHALL update dcsr_prv WARL: 0,3 accepted; 1 accepted if SUPPORT_SUPER else 0; 2 retains old value.
REQ-028 dbg_resume_i in DEBUG SHALL go RESUME: priv<=dcsr_prv, dbg_mode_o<=0, then RUN next cycle; resume outside DEBUG ignored.
REQ-029 dbg_prv_wr_i and dbg_resume_i same cycle SHALL resume with the newly written (WARL-legalised) value.

Reset
REQ-030 Reset SHALL force state RUN, priv_o=M, mpp_o=U, spp_o=0, dcsr_prv=M, dbg_mode_o=0, ack_o=0, illegal_o=0.
REQ-031 Reset asserted mid-HALT/DEBUG/RESUME SHALL abort immediately to reset values; no pending event survives.

Structure
REQ-032 Privilege constants (PRIV_USER, PRIV_SUPER, PRIV_MACHINE) and FSM state enum SHALL live in shared package riscv_priv_pkg.
REQ-033 SHALL be a single module; WARL legalisation as a package function, no sub-module.

Verification
REQ-034 Reset, then trap_valid_i deleg=0 -> next cycle priv_o=3, mpp_o=3, ack_o=1; mret_i -> priv_o=3, mpp_o=0.
REQ-035 Reach U (priv_o=0), trap deleg=1 -> priv_o=1, spp_o=0; sret_i -> priv_o=0; second sret_i -> illegal_o=1, priv_o stays 0.
REQ-036 In U, dbg_req_i and trap_valid_i same cycle -> debug wins, dbg_mode_o=1 after 2 cycles, priv_o=3, mpp_o unchanged.
REQ-037 In DEBUG write dbg_prv_i=2 -> dcsr_prv unchanged (0); write 1 with resume same cycle -> priv_o=1, dbg_mode_o=0.
REQ-038 SUPPORT_SUPER=0: trap deleg=1 from U -> priv_o=3; sret_i -> illegal_o=1; dcsr write 1 then resume -> priv_o=0.
REQ-039 rst_i asserted during DEBUG -> same cycle (async) dbg_mode_o=0, priv_o=3, FSM RUN.
